// File: rtl/weight_fetch_ctrl.sv
// Initiator-side controller for a single-port weight BRAM: loads DEPTH words from a host
// stream, or streams all DEPTH words to the MAC over valid/ready with a 2-entry skid FIFO.
module weight_fetch_ctrl #(
    parameter int DEPTH  = 28,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_mode,
    input  logic [DATA_W-1:0] i_ld_data,
    input  logic              i_ld_valid,
    output logic              o_ld_ready,
    output logic [DATA_W-1:0] o_w_data,
    output logic              o_w_valid,
    input  logic              i_w_ready,
    output logic [ADDR_W-1:0] o_w_index,
    output logic              o_w_last,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_bram_addr,
    output logic [DATA_W-1:0] o_bram_di,
    output logic              o_bram_en,
    output logic              o_bram_we,
    input  logic [DATA_W-1:0] i_bram_do
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FETCH,
        S_DRAIN
    } state_t;

    localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LP_WLAST = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] LP_ILAST = ADDR_W'(DEPTH - 1);

    state_t r_state;
    state_t w_state_nxt;

    // Pointers carry one extra bit so reaching DEPTH never aliases address 0.
    logic [ADDR_W:0]   r_wptr;
    logic [ADDR_W:0]   r_rptr;
    logic              r_inflight;

    logic [DATA_W-1:0] r_fifo_data [2];
    logic [ADDR_W-1:0] r_fifo_idx  [2];
    logic              r_head;
    logic [1:0]        r_count;

    logic              r_done;
    logic [ADDR_W-1:0] r_bram_addr;
    logic [DATA_W-1:0] r_bram_di;
    logic              r_bram_en;
    logic              r_bram_we;

    logic              w_pop;
    logic              w_push;
    logic [2:0]        w_occ;
    logic              w_issue;
    logic              w_beat;
    logic              w_last_beat;
    logic              w_last_pop;
    logic              w_wr_sel;

    logic              w_done_nxt;
    logic              w_en_nxt;
    logic              w_we_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] w_di_nxt;

    assign o_w_valid  = (r_count != 2'd0);
    assign o_w_data   = r_fifo_data[r_head];
    assign o_w_index  = r_fifo_idx[r_head];
    assign o_w_last   = o_w_valid && (o_w_index == LP_ILAST);
    assign o_ld_ready = (r_state == S_LOAD);
    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = r_done;
    assign o_bram_addr = r_bram_addr;
    assign o_bram_di   = r_bram_di;
    assign o_bram_en   = r_bram_en;
    assign o_bram_we   = r_bram_we;

    assign w_pop  = o_w_valid && i_w_ready;
    assign w_push = r_inflight;

    // Occupancy after this cycle's pop, counting the read whose data lands at the next edge.
    assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue = (r_state == S_FETCH) && (w_occ < 3'd2) && (r_rptr < LP_DEPTH);

    assign w_beat      = (r_state == S_LOAD) && i_ld_valid;
    assign w_last_beat = w_beat && (r_wptr == LP_WLAST);
    assign w_last_pop  = (r_state == S_DRAIN) && w_pop && (o_w_index == LP_ILAST);

    assign w_wr_sel = r_head ^ r_count[0];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = w_last_beat || w_last_pop;
        w_en_nxt    = w_beat || w_issue;
        w_we_nxt    = w_beat;
        w_addr_nxt  = r_bram_addr;
        w_di_nxt    = r_bram_di;
        if (w_beat) begin
            w_addr_nxt = r_wptr[ADDR_W-1:0];
            w_di_nxt   = i_ld_data;
        end else if (w_issue) begin
            w_addr_nxt = r_rptr[ADDR_W-1:0];
        end
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = i_mode ? S_LOAD : S_FETCH;
            S_LOAD:  if (w_last_beat) w_state_nxt = S_IDLE;
            S_FETCH: if (r_rptr == LP_DEPTH) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_last_pop) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (r_state == S_IDLE) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_beat) r_wptr <= r_wptr + 1'b1;
                if (w_issue) r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_done      <= 1'b0;
            r_bram_en   <= 1'b0;
            r_bram_we   <= 1'b0;
            r_bram_addr <= '0;
            r_bram_di   <= '0;
        end else begin
            r_done      <= w_done_nxt;
            r_bram_en   <= w_en_nxt;
            r_bram_we   <= w_we_nxt;
            r_bram_addr <= w_addr_nxt;
            r_bram_di   <= w_di_nxt;
        end
    end

    // The outstanding read address is still on r_bram_addr when its data is captured.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
            r_fifo_idx[0]  <= '0;
            r_fifo_idx[1]  <= '0;
            r_head         <= 1'b0;
            r_count        <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_data[w_wr_sel] <= i_bram_do;
                r_fifo_idx[w_wr_sel]  <= r_bram_addr;
            end
            if (w_pop) r_head <= ~r_head;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Self-checking bench for weight_fetch_ctrl: BRAM model, stream-level reference model
// checked every cycle, and directed load/fetch scenarios with hand-computed timing.
module tb_weight_fetch_ctrl;

    localparam int DEPTH     = 28;
    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 16;
    localparam int OP_BUDGET = 400;

    logic              clk = 1'b0;
    logic              i_rst;
    logic              i_start;
    logic              i_mode;
    logic [DATA_W-1:0] i_ld_data;
    logic              i_ld_valid;
    logic              o_ld_ready;
    logic [DATA_W-1:0] o_w_data;
    logic              o_w_valid;
    logic              i_w_ready;
    logic [ADDR_W-1:0] o_w_index;
    logic              o_w_last;
    logic              o_busy;
    logic              o_done;
    logic [ADDR_W-1:0] o_bram_addr;
    logic [DATA_W-1:0] o_bram_di;
    logic              o_bram_en;
    logic              o_bram_we;
    logic [DATA_W-1:0] bramDo = '0;

    logic [DATA_W-1:0] bramMem [0:31];
    logic [DATA_W-1:0] expMem  [0:DEPTH-1];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int reqKind = 0;
    int opSeq = 0;
    int seenSeq = 0;
    int kEdge = 0;

    int opKind = 0;
    int beats = 0;
    int expWr = 0;
    int expRd = 0;
    int expPop = 0;
    int issued = 0;
    int popped = 0;
    int wrCount = 0;
    int doneCount = 0;
    int firstValidCyc = -1;
    int lastIdxCyc = -1;
    int doneCyc = -1;
    logic [DATA_W-1:0] firstData = '0;
    bit beatPrev = 0;
    bit stallPrev = 0;
    bit doneExp = 0;

    weight_fetch_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_mode(i_mode),
        .i_ld_data(i_ld_data), .i_ld_valid(i_ld_valid), .o_ld_ready(o_ld_ready),
        .o_w_data(o_w_data), .o_w_valid(o_w_valid), .i_w_ready(i_w_ready),
        .o_w_index(o_w_index), .o_w_last(o_w_last), .o_busy(o_busy), .o_done(o_done),
        .o_bram_addr(o_bram_addr), .o_bram_di(o_bram_di), .o_bram_en(o_bram_en),
        .o_bram_we(o_bram_we), .i_bram_do(bramDo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port BRAM that samples its port and updates DO on the falling edge.
    always @(negedge clk) begin
        if (o_bram_en) begin
            if (o_bram_we) bramMem[o_bram_addr] <= o_bram_di;
            else bramDo <= bramMem[o_bram_addr];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkAllZero();
        checkOutput("zero_ld_ready", 32'(o_ld_ready), 0);
        checkOutput("zero_w_valid", 32'(o_w_valid), 0);
        checkOutput("zero_w_last", 32'(o_w_last), 0);
        checkOutput("zero_w_index", 32'(o_w_index), 0);
        checkOutput("zero_w_data", 32'(o_w_data), 0);
        checkOutput("zero_busy", 32'(o_busy), 0);
        checkOutput("zero_done", 32'(o_done), 0);
        checkOutput("zero_bram_en", 32'(o_bram_en), 0);
        checkOutput("zero_bram_we", 32'(o_bram_we), 0);
        checkOutput("zero_bram_addr", 32'(o_bram_addr), 0);
        checkOutput("zero_bram_di", 32'(o_bram_di), 0);
    endtask

    function automatic logic readyAt(input int pattern, input int n);
        case (pattern)
            1: return ((n % 4) == 0) || ((n % 4) == 3);
            2: return (n >= 20);
            default: return 1'b1;
        endcase
    endfunction

    // Reference model: an operation is a stream of DEPTH beats or DEPTH ordered words.
    task automatic compareLoop();
        bit wrNow;
        bit rdNow;
        bit expReady;
        bit beatNow;
        bit lastEvt;
        forever begin
            @(negedge clk);
            if (i_rst) begin
                opKind = 0; beats = 0; expWr = 0; expRd = 0; expPop = 0;
                issued = 0; popped = 0; beatPrev = 0; stallPrev = 0; doneExp = 0;
            end else begin
                if (opSeq != seenSeq) begin
                    seenSeq = opSeq; opKind = reqKind;
                    beats = 0; expWr = 0; expRd = 0; expPop = 0; issued = 0; popped = 0;
                    wrCount = 0; doneCount = 0; firstValidCyc = -1; lastIdxCyc = -1; doneCyc = -1;
                end
                expReady = (opKind == 2) && (beats < DEPTH);
                checkOutput("ld_ready", 32'(o_ld_ready), 32'(expReady));
                checkOutput("busy", 32'(o_busy), 32'(opKind != 0));
                checkOutput("done", 32'(o_done), 32'(doneExp));
                if (o_done) begin
                    doneCount++;
                    doneCyc = cyc;
                end

                wrNow = o_bram_en && o_bram_we;
                rdNow = o_bram_en && !o_bram_we;
                checkOutput("bram_write_follows_beat", 32'(wrNow), 32'(beatPrev));
                if (wrNow) begin
                    checkOutput("bram_wr_addr", 32'(o_bram_addr), 32'(expWr));
                    checkOutput("bram_wr_di", 32'(o_bram_di), 32'(expMem[expWr % DEPTH]));
                    expWr++;
                    wrCount++;
                end
                if (opKind != 1) checkOutput("read_outside_fetch", 32'(rdNow), 0);
                if (rdNow) begin
                    checkOutput("bram_rd_addr", 32'(o_bram_addr), 32'(expRd));
                    expRd++;
                    issued++;
                end
                checkOutput("outstanding_le2", 32'((issued - popped) <= 2), 1);

                if (stallPrev) checkOutput("w_valid_hold", 32'(o_w_valid), 1);
                if (opKind == 0) checkOutput("w_valid_idle", 32'(o_w_valid), 0);
                if (o_w_valid) begin
                    checkOutput("w_index", 32'(o_w_index), 32'(expPop));
                    checkOutput("w_data", 32'(o_w_data), 32'(expMem[expPop % DEPTH]));
                    checkOutput("w_last", 32'(o_w_last), 32'(expPop == DEPTH - 1));
                    if (firstValidCyc < 0) begin
                        firstValidCyc = cyc;
                        firstData = o_w_data;
                    end
                    if (expPop == DEPTH - 1 && lastIdxCyc < 0) lastIdxCyc = cyc;
                end else begin
                    checkOutput("w_last_idle", 32'(o_w_last), 0);
                end

                lastEvt = 0;
                beatNow = i_ld_valid && expReady;
                if (beatNow) begin
                    beats++;
                    if (beats == DEPTH) lastEvt = 1;
                end
                if (o_w_valid && i_w_ready) begin
                    if (expPop == DEPTH - 1) lastEvt = 1;
                    expPop++;
                    popped++;
                end
                stallPrev = o_w_valid && !i_w_ready;
                beatPrev = beatNow;
                doneExp = lastEvt;
                if (lastEvt) opKind = 0;
            end
        end
    endtask

    // kind 1 = fetch, 2 = load; abortIdx >= 0 resets the DUT when that index is on W_DATA.
    task automatic applyStimulus(input int kind, input int pattern, input int gap,
                                 input int abortIdx, input bit midStart);
        int ldIdx;
        bit finished;
        ldIdx = 0;
        finished = 0;
        @(posedge clk); #1;
        i_start = 1'b1;
        i_mode = (kind == 2);
        @(posedge clk); #1;
        i_start = 1'b0;
        i_mode = 1'b0;
        kEdge = cyc;
        reqKind = kind;
        opSeq++;
        for (int n = 0; n < OP_BUDGET && !finished; n++) begin
            if (pattern == 2 && n == 20) begin
                checkOutput("stall_reads_issued", 32'(issued), 2);
                checkOutput("stall_w_valid", 32'(o_w_valid), 1);
                checkOutput("stall_w_data", 32'(o_w_data), 32'h0100);
                checkOutput("stall_w_index", 32'(o_w_index), 0);
            end
            i_w_ready = readyAt(pattern, n);
            if (kind == 2) begin
                i_ld_valid = ((n % gap) == 0) && (ldIdx < DEPTH);
                i_ld_data = i_ld_valid ? expMem[ldIdx % DEPTH] : '0;
            end else begin
                i_ld_valid = midStart;
                i_ld_data = 16'hDEAD;
            end
            if (midStart) begin
                i_start = (n == 5);
                i_mode = (n == 5);
            end
            @(negedge clk);
            if (i_ld_valid && o_ld_ready) ldIdx++;
            if (abortIdx >= 0 && o_w_valid && o_w_index == ADDR_W'(abortIdx)) begin
                #2 i_rst = 1'b1;
                #1 checkAllZero();
                i_ld_valid = 1'b0;
                i_w_ready = 1'b0;
                @(negedge clk);
                @(posedge clk); #3;
                i_rst = 1'b0;
                finished = 1;
            end else begin
                @(posedge clk); #1;
                if (opKind == 0) finished = 1;
            end
        end
        i_ld_valid = 1'b0;
        i_start = 1'b0;
        i_mode = 1'b0;
        i_w_ready = 1'b1;
        checkOutput("op_finished_in_budget", 32'(finished), 1);
        if (!finished) begin
            i_rst = 1'b1;
            @(negedge clk);
            @(posedge clk); #3;
            i_rst = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        i_rst = 1'b1;
        i_start = 1'b0;
        i_mode = 1'b0;
        i_ld_data = '0;
        i_ld_valid = 1'b0;
        i_w_ready = 1'b1;
        fork
            compareLoop();
        join_none
        repeat (2) @(posedge clk);
        #1 checkAllZero();
        @(posedge clk); #3;
        i_rst = 1'b0;

        $display("[TB] load 0x0100+i, back-to-back");
        for (int i = 0; i < DEPTH; i++) expMem[i] = 16'(16'h0100 + i);
        applyStimulus(2, 0, 1, -1, 0);
        checkOutput("load_writes", 32'(wrCount), 28);
        checkOutput("load_done_count", 32'(doneCount), 1);
        checkOutput("load_done_cycle", 32'(doneCyc - kEdge), 28);

        $display("[TB] fetch with W_READY held high");
        applyStimulus(1, 0, 1, -1, 0);
        checkOutput("fetch_first_valid_cycle", 32'(firstValidCyc - kEdge), 2);
        checkOutput("fetch_first_data", 32'(firstData), 32'h0100);
        checkOutput("fetch_last_word_cycle", 32'(lastIdxCyc - kEdge), 29);
        checkOutput("fetch_done_cycle", 32'(doneCyc - kEdge), 30);
        checkOutput("fetch_popped", 32'(popped), 28);
        checkOutput("fetch_done_count", 32'(doneCount), 1);

        $display("[TB] fetch with W_READY pattern 1,0,0,1");
        applyStimulus(1, 1, 1, -1, 0);
        checkOutput("bp_popped", 32'(popped), 28);
        checkOutput("bp_issued", 32'(issued), 28);
        checkOutput("bp_done_count", 32'(doneCount), 1);

        $display("[TB] fetch with W_READY low for 20 cycles");
        applyStimulus(1, 2, 1, -1, 0);
        checkOutput("hold_popped", 32'(popped), 28);
        checkOutput("hold_done_count", 32'(doneCount), 1);

        $display("[TB] fetch with START/MODE=1 pulsed midway and LD_VALID high");
        applyStimulus(1, 0, 1, -1, 1);
        checkOutput("midstart_popped", 32'(popped), 28);
        checkOutput("midstart_writes", 32'(wrCount), 0);
        checkOutput("midstart_done_count", 32'(doneCount), 1);

        $display("[TB] fetch aborted by reset at index 10, then refetch");
        applyStimulus(1, 0, 1, 10, 0);
        applyStimulus(1, 0, 1, -1, 0);
        checkOutput("refetch_first_valid_cycle", 32'(firstValidCyc - kEdge), 2);
        checkOutput("refetch_first_data", 32'(firstData), 32'h0100);
        checkOutput("refetch_done_cycle", 32'(doneCyc - kEdge), 30);
        checkOutput("refetch_popped", 32'(popped), 28);

        $display("[TB] load 0xC000+3i with LD_VALID every third cycle");
        for (int i = 0; i < DEPTH; i++) expMem[i] = 16'(16'hC000 + 3 * i);
        applyStimulus(2, 0, 3, -1, 0);
        checkOutput("gap_load_writes", 32'(wrCount), 28);
        checkOutput("gap_load_done_cycle", 32'(doneCyc - kEdge), 82);
        checkOutput("gap_load_done_count", 32'(doneCount), 1);

        $display("[TB] fetch of the reloaded contents");
        applyStimulus(1, 0, 1, -1, 0);
        checkOutput("reload_first_data", 32'(firstData), 32'hC000);
        checkOutput("reload_popped", 32'(popped), 28);
        checkOutput("reload_done_count", 32'(doneCount), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/weight_fetch_ctrl.md
Name: weight_fetch_ctrl

Overview:
- Initiator-side controller for one single-port weight BRAM.
- Memory port: ADDR/DI/EN/WE/DO, 16-bit words, depth 28; the BRAM samples its inputs and updates DO on the negedge of CLK.
- Two modes:
  - Load: accepts DEPTH words from a host stream and writes them into the BRAM.
  - Fetch: reads all DEPTH words in address order and streams them to the neuron MAC over a valid/ready handshake, with full backpressure support.

Parameters:
- DEPTH, 28, number of weights per BRAM (addresses 0..DEPTH-1).
- ADDR_W, 5, BRAM address width; must satisfy 2^ADDR_W >= DEPTH.
- DATA_W, 16, weight word width.

Ports:
- CLK  in  1  system clock; all controller registers on posedge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  begin operation; sampled only in IDLE.
- MODE  in  1  sampled with START; 0 = fetch, 1 = load.
- LD_DATA  in  DATA_W  host load word.
- LD_VALID  in  1  host word valid.
- LD_READY  out  1  controller accepts a load word.
- W_DATA  out  DATA_W  weight to MAC.
- W_VALID  out  1  W_DATA valid.
- W_READY  in  1  MAC accepts the word.
- W_INDEX  out  ADDR_W  address of the current W_DATA.
- W_LAST  out  1  high with the word at index DEPTH-1.
- BUSY  out  1  high whenever the state is not IDLE.
- DONE  out  1  one-cycle pulse when an operation completes.
- BRAM_ADDR  out  ADDR_W  to BRAM ADDR.
- BRAM_DI  out  DATA_W  to BRAM DI.
- BRAM_EN  out  1  to BRAM EN.
- BRAM_WE  out  1  to BRAM WE.
- BRAM_DO  in  DATA_W  from BRAM DO.

Behaviour:
- Reset (async, RST=1):
  - State = IDLE; pointers, buffer and in-flight flag cleared.
  - All outputs 0: LD_READY, W_VALID, W_LAST, W_INDEX, W_DATA, BUSY, DONE, BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_DI.
  - Reset mid-operation aborts immediately: buffered words are discarded and no DONE is issued.
- States: IDLE, LOAD, FETCH, DRAIN.
- All BRAM_* outputs are registered.
- IDLE:
  - START=1 at posedge -> LOAD if MODE=1, else FETCH.
  - Read and write pointers are cleared to 0.
  - START while not in IDLE is ignored.
- LOAD:
  - LD_READY=1.
  - Each beat with LD_VALID & LD_READY drives BRAM_EN=1, BRAM_WE=1, BRAM_ADDR=wptr, BRAM_DI=LD_DATA in the following cycle, then wptr increments.
  - BRAM_EN and BRAM_WE are 0 in any cycle with no beat.
  - On the DEPTH-th accepted beat, LD_READY drops in the next cycle.
  - DONE pulses in the cycle the last write is presented to the BRAM, then the state returns to IDLE.
  - LD_VALID in IDLE or FETCH is ignored.
- FETCH (read issue):
  - Issue = BRAM_EN=1, BRAM_WE=0, BRAM_ADDR=rptr for one cycle; rptr increments.
  - The BRAM updates DO at the negedge within the issue cycle; BRAM_DO is captured at the next posedge.
  - Read latency is 1 cycle. An in-flight flag tracks the outstanding read.
- Output buffer:
  - 2-entry FIFO of {data, index}; W_DATA/W_INDEX/W_VALID are driven from the head.
  - pop = W_VALID & W_READY.
- Issue rule:
  - A read may be registered for the next cycle only if (count + inflight - pop) < 2 and rptr < DEPTH.
  - This guarantees no overflow and no dropped words under arbitrary W_READY patterns.
  - With W_READY held at 1, one word is delivered every cycle.
- Hold rules:
  - W_DATA and W_INDEX stay stable while W_VALID=1 and W_READY=0.
  - W_LAST = W_VALID & (W_INDEX == DEPTH-1).
- FETCH -> DRAIN once rptr reaches DEPTH. BRAM_EN stays 0 in DRAIN.
- DRAIN:
  - DONE pulses in the cycle after the pop of the W_LAST word.
  - The state returns to IDLE in that same cycle.
- Timing from START sampled at edge k (fetch, W_READY=1):
  - ADDR 0 is presented during cycle k+1.
  - Word 0 is on W_DATA from edge k+2.
  - Word DEPTH-1 is on W_DATA from edge k+DEPTH+1.
  - DONE is high during cycle k+DEPTH+2.
- Simultaneous push and pop on the FIFO is allowed; count is unchanged.
- Pointer widths are ADDR_W+1 internally, so no wrap-around occurs at DEPTH.

Test Plan:
- Load then fetch: load words 0x0100+i for i=0..27 -> 28 BRAM writes at ADDR 0..27 with matching DI and one DONE; then fetch with W_READY=1 -> W_DATA 0x0100..0x011B on 28 consecutive cycles starting 2 cycles after START, W_LAST only on index 27, DONE one cycle after the last pop.
- Backpressure: W_READY toggles 1,0,0,1 repeating during fetch -> all 28 words delivered in order with no duplicates; W_DATA stable while stalled; BRAM_EN never asserted when count+inflight would exceed 2.
- W_READY held 0 for 20 cycles after START -> exactly 2 reads issued (ADDR 0,1), W_DATA=word 0 held; on release, words resume from index 0.
- START pulsed mid-fetch with MODE=1 -> ignored; LD_READY stays 0; fetch completes normally with a single DONE.
- RST asserted at index 10 of a fetch -> all outputs 0 asynchronously; a new START then fetches from index 0 with correct data.
- Load with LD_VALID gaps (valid every 3rd cycle) -> exactly 28 writes to addresses 0..27 in order; BRAM_EN=0 in every gap cycle.
